// File: rtl/compliance_obi_mem.sv
// compliance_obi_mem: dual-port OBI memory responder for the compliance harness.
//
// Models fixed-latency SRAM behind the core's instruction and data OBI channels.
// Each port has a bounded number of in-flight transactions, in-order responses
// delivered through a RespLatency-deep pipeline, an out-of-range error response,
// and the data port watches for the tohost write that ends a test.
// Memory contents are not reset and are expected to be backdoor-loaded.
//
// Optional build macro: COMPLIANCE_MEM_STALL_EN adds per-port LFSR grant stalls.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   instr_req_i / instr_gnt_o     instruction request / combinational grant
//   instr_addr_i                  instruction byte address (read-only port)
//   instr_rvalid_o, instr_rdata_o, instr_err_o   instruction response
//   data_req_i / data_gnt_o       data request / combinational grant
//   data_we_i, data_be_i, data_addr_i, data_wdata_i   data request payload
//   data_rvalid_o, data_rdata_o, data_err_o      data response
//   halt_o, exit_code_o, pass_o   sticky tohost status

module compliance_obi_mem #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemWords       = 16384,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ToHostAddr     = 32'h0000_F000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        halt_o,
    output logic [30:0] exit_code_o,
    output logic        pass_o
);

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam int unsigned CntW = 3;
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);

    logic [31:0] mem [MemWords];

    // Unsigned 32-bit compare, no wrap: addresses below the base are out of range.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - MemBase;
        return (addr >= MemBase) && ((off >> 2) < MemWords);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - MemBase;
        return IdxW'(off >> 2);
    endfunction

    // ---------------------------------------------------------------- grant stalls
    logic instr_stall, data_stall;

`ifdef COMPLIANCE_MEM_STALL_EN
    logic [15:0] instr_lfsr_q, data_lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_lfsr_q <= 16'hACE1;
            data_lfsr_q  <= 16'h1D2B;
        end else begin
            instr_lfsr_q <= {instr_lfsr_q[14:0],
                             instr_lfsr_q[15] ^ instr_lfsr_q[13] ^
                             instr_lfsr_q[12] ^ instr_lfsr_q[10]};
            data_lfsr_q  <= {data_lfsr_q[14:0],
                             data_lfsr_q[15] ^ data_lfsr_q[13] ^
                             data_lfsr_q[12] ^ data_lfsr_q[10]};
        end
    end

    assign instr_stall = (instr_lfsr_q[1:0] == 2'b00);
    assign data_stall  = (data_lfsr_q[1:0] == 2'b00);
`else
    assign instr_stall = 1'b0;
    assign data_stall  = 1'b0;
`endif

    // ---------------------------------------------------------------- grant / accept
    logic [CntW-1:0] instr_cnt_q, data_cnt_q;
    logic            instr_acc, data_acc;

    assign instr_gnt_o = instr_req_i & (instr_cnt_q < MaxOut) & ~instr_stall;
    assign data_gnt_o  = data_req_i & (data_cnt_q < MaxOut) & ~data_stall;
    assign instr_acc   = instr_req_i & instr_gnt_o;
    assign data_acc    = data_req_i & data_gnt_o;

    // ---------------------------------------------------------------- array read
    logic            instr_in_range, data_in_range;
    logic [IdxW-1:0] instr_idx, data_idx;
    logic [31:0]     instr_rd, data_rd;

    assign instr_in_range = addr_in_range(instr_addr_i);
    assign data_in_range  = addr_in_range(data_addr_i);
    assign instr_idx      = word_idx(instr_addr_i);
    assign data_idx       = word_idx(data_addr_i);

    // Sampled on the accept edge, before that edge's write lands (read-before-write).
    assign instr_rd = instr_in_range ? mem[instr_idx] : 32'h0;
    assign data_rd  = (data_in_range && !data_we_i) ? mem[data_idx] : 32'h0;

    // ---------------------------------------------------------------- array write
    always_ff @(posedge clk_i) begin
        if (data_acc && data_we_i && data_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[data_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- response pipelines
    logic [RespLatency-1:0] instr_v_q, instr_e_q, data_v_q, data_e_q;
    logic [31:0]            instr_d_q [RespLatency];
    logic [31:0]            data_d_q  [RespLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_v_q <= '0;
            instr_e_q <= '0;
            data_v_q  <= '0;
            data_e_q  <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                instr_d_q[i] <= '0;
                data_d_q[i]  <= '0;
            end
        end else begin
            instr_v_q[0] <= instr_acc;
            instr_e_q[0] <= instr_acc & ~instr_in_range;
            instr_d_q[0] <= instr_acc ? instr_rd : 32'h0;
            data_v_q[0]  <= data_acc;
            data_e_q[0]  <= data_acc & ~data_in_range;
            data_d_q[0]  <= data_acc ? data_rd : 32'h0;
            for (int i = 1; i < RespLatency; i++) begin
                instr_v_q[i] <= instr_v_q[i-1];
                instr_e_q[i] <= instr_e_q[i-1];
                instr_d_q[i] <= instr_d_q[i-1];
                data_v_q[i]  <= data_v_q[i-1];
                data_e_q[i]  <= data_e_q[i-1];
                data_d_q[i]  <= data_d_q[i-1];
            end
        end
    end

    assign instr_rvalid_o = instr_v_q[RespLatency-1];
    assign instr_err_o    = instr_e_q[RespLatency-1];
    assign instr_rdata_o  = instr_d_q[RespLatency-1];
    assign data_rvalid_o  = data_v_q[RespLatency-1];
    assign data_err_o     = data_e_q[RespLatency-1];
    assign data_rdata_o   = data_d_q[RespLatency-1];

    // ---------------------------------------------------------------- outstanding count
    // A transaction stops counting on the edge that launches its rvalid, i.e. the
    // edge that moves it into the last pipeline stage. With a single stage that is
    // the accept edge itself.
    logic instr_rise, data_rise;

    if (RespLatency == 1) begin : g_rise_single
        assign instr_rise = instr_acc;
        assign data_rise  = data_acc;
    end else begin : g_rise_multi
        assign instr_rise = instr_v_q[RespLatency-2];
        assign data_rise  = data_v_q[RespLatency-2];
    end

    logic [CntW-1:0] instr_cnt_d, data_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q + CntW'(instr_acc) - CntW'(instr_rise);
        data_cnt_d  = data_cnt_q + CntW'(data_acc) - CntW'(data_rise);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_cnt_q <= '0;
            data_cnt_q  <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            data_cnt_q  <= data_cnt_d;
        end
    end

    // ---------------------------------------------------------------- tohost
    logic        halt_q, pass_q;
    logic [30:0] exit_q;
    logic        tohost_hit;

    assign tohost_hit = data_acc && data_we_i && (data_be_i == 4'b1111) &&
                        (data_addr_i == ToHostAddr);

    // First tohost write wins; later ones leave the latched status alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q <= 1'b0;
            pass_q <= 1'b0;
            exit_q <= '0;
        end else if (tohost_hit && !halt_q) begin
            halt_q <= 1'b1;
            pass_q <= (data_wdata_i == 32'h1);
            exit_q <= data_wdata_i[31:1];
        end
    end

    assign halt_o      = halt_q;
    assign pass_o      = pass_q;
    assign exit_code_o = exit_q;

endmodule

// File: tb/tb_compliance_obi_mem.sv
// Self-checking bench for compliance_obi_mem. Instance u_a uses the default
// single-cycle latency; instance u_b uses RespLatency=3, MaxOutstanding=2.
// Drivers push expected responses into per-port queues; a negedge monitor pops
// and compares whenever a DUT raises rvalid.

module tb_compliance_obi_mem;

    localparam logic [31:0] MEM_BASE  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 16384;
    localparam logic [31:0] TOHOST    = 32'h0000_F000;
    localparam int          LA        = 1;
    localparam int          LB        = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A signals
    logic        a_ireq, a_igl, a_irvalid, a_ierr;
    logic [31:0] a_iaddr, a_irdata;
    logic        a_dreq, a_dgnt, a_drvalid, a_dwe, a_derr;
    logic [3:0]  a_dbe;
    logic [31:0] a_daddr, a_dwdata, a_drdata;
    logic        a_halt, a_pass;
    logic [30:0] a_exit;
    // DUT B signals
    logic        b_ireq, b_igl, b_irvalid, b_ierr;
    logic [31:0] b_iaddr, b_irdata;
    logic        b_dreq, b_dgnt, b_drvalid, b_dwe, b_derr;
    logic [3:0]  b_dbe;
    logic [31:0] b_daddr, b_dwdata, b_drdata;
    logic        b_halt, b_pass;
    logic [30:0] b_exit;

    compliance_obi_mem u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(a_ireq), .instr_gnt_o(a_igl), .instr_rvalid_o(a_irvalid),
        .instr_addr_i(a_iaddr), .instr_rdata_o(a_irdata), .instr_err_o(a_ierr),
        .data_req_i(a_dreq), .data_gnt_o(a_dgnt), .data_rvalid_o(a_drvalid),
        .data_we_i(a_dwe), .data_be_i(a_dbe), .data_addr_i(a_daddr),
        .data_wdata_i(a_dwdata), .data_rdata_o(a_drdata), .data_err_o(a_derr),
        .halt_o(a_halt), .exit_code_o(a_exit), .pass_o(a_pass)
    );

    compliance_obi_mem #(.RespLatency(3), .MaxOutstanding(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(b_ireq), .instr_gnt_o(b_igl), .instr_rvalid_o(b_irvalid),
        .instr_addr_i(b_iaddr), .instr_rdata_o(b_irdata), .instr_err_o(b_ierr),
        .data_req_i(b_dreq), .data_gnt_o(b_dgnt), .data_rvalid_o(b_drvalid),
        .data_we_i(b_dwe), .data_be_i(b_dbe), .data_addr_i(b_daddr),
        .data_wdata_i(b_dwdata), .data_rdata_o(b_drdata), .data_err_o(b_derr),
        .halt_o(b_halt), .exit_code_o(b_exit), .pass_o(b_pass)
    );

    int n_checks = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, req);
    endfunction

    // ------------------------------------------------------------ reference model
    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t qa_i[$], qa_d[$], qb_i[$], qb_d[$];

    logic [31:0] ref_a [int];
    logic [31:0] ref_b [int];
    logic        ref_halted = 1'b0;

    function automatic logic ref_in_range(logic [31:0] addr);
        return (addr >= MEM_BASE) && ((addr - MEM_BASE) / 4 < MEM_WORDS);
    endfunction

    function automatic int ref_word(logic [31:0] addr);
        return int'((addr - MEM_BASE) / 4);
    endfunction

    function automatic logic [31:0] ref_a_get(int w);
        return ref_a.exists(w) ? ref_a[w] : 32'h0;
    endfunction

    task automatic model_instr(input logic [31:0] addr, output logic [31:0] rd,
                               output logic er);
        er = !ref_in_range(addr);
        rd = er ? 32'h0 : ref_a_get(ref_word(addr));
    endtask

    task automatic model_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] w;
        er = !ref_in_range(addr);
        rd = 32'h0;
        if (!er && !we) rd = ref_a_get(ref_word(addr));
        if (!er && we) begin
            w = ref_a_get(ref_word(addr));
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_a[ref_word(addr)] = w;
        end
        if (we && be == 4'hF && addr == TOHOST) ref_halted = 1'b1;
    endtask

    // ------------------------------------------------------------ drivers
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One cycle on DUT A; called at posedge+1, returns at the next posedge+1.
    task automatic a_cycle(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic dwe, input logic [3:0] dbe,
                           input logic [31:0] daddr, input logic [31:0] dwd,
                           output logic ig, output logic dg);
        logic [31:0] rd;
        logic        er;
        a_ireq = ireq; a_iaddr = iaddr;
        a_dreq = dreq; a_dwe = dwe; a_dbe = dbe; a_daddr = daddr; a_dwdata = dwd;
        @(negedge clk);
        ig = a_igl;
        dg = a_dgnt;
        // Instruction read is modelled first so a same-edge data write is not seen.
        if (ireq && ig) begin
            model_instr(iaddr, rd, er);
            qa_i.push_back('{cyc + LA, rd, er});
        end
        if (dreq && dg) begin
            model_data(dwe, dbe, daddr, dwd, rd, er);
            qa_d.push_back('{cyc + LA, rd, er});
        end
        @(posedge clk);
        #1;
        a_ireq = 1'b0;
        a_dreq = 1'b0;
    endtask

    task automatic b_read(input logic [31:0] addr, output logic g);
        logic [31:0] rd;
        b_dreq = 1'b1; b_dwe = 1'b0; b_dbe = 4'h0; b_daddr = addr;
        @(negedge clk);
        g = b_dgnt;
        if (g) begin
            rd = ref_b.exists(ref_word(addr)) ? ref_b[ref_word(addr)] : 32'h0;
            qb_d.push_back('{cyc + LB, rd, 1'b0});
        end
        @(posedge clk);
        #1;
        b_dreq = 1'b0;
    endtask

    // ------------------------------------------------------------ monitor
    exp_t e;
    int   b_rv_cnt = 0;

    function automatic void cmp_resp(string nm, exp_t x, logic [31:0] rd, logic er);
        chk({nm, " timing"}, cyc, x.due);
        chk({nm, " rdata"}, rd, x.rdata);
        chk({nm, " err"}, {31'h0, er}, {31'h0, x.err});
    endfunction

    always @(negedge clk) begin
        if (b_drvalid) b_rv_cnt++;
        if (rst_n) begin
            if (a_irvalid) begin
                if (qa_i.size() == 0) chk("a_instr unexpected rvalid", 1, 0);
                else begin e = qa_i.pop_front(); cmp_resp("a_instr", e, a_irdata, a_ierr); end
            end else if (qa_i.size() != 0 && qa_i[0].due < cyc) begin
                e = qa_i.pop_front(); chk("a_instr missing rvalid", 0, 1);
            end
            if (a_drvalid) begin
                if (qa_d.size() == 0) chk("a_data unexpected rvalid", 1, 0);
                else begin e = qa_d.pop_front(); cmp_resp("a_data", e, a_drdata, a_derr); end
            end else if (qa_d.size() != 0 && qa_d[0].due < cyc) begin
                e = qa_d.pop_front(); chk("a_data missing rvalid", 0, 1);
            end
            if (b_irvalid) begin
                if (qb_i.size() == 0) chk("b_instr unexpected rvalid", 1, 0);
                else begin e = qb_i.pop_front(); cmp_resp("b_instr", e, b_irdata, b_ierr); end
            end
            if (b_drvalid) begin
                if (qb_d.size() == 0) chk("b_data unexpected rvalid", 1, 0);
                else begin e = qb_d.pop_front(); cmp_resp("b_data", e, b_drdata, b_derr); end
            end else if (qb_d.size() != 0 && qb_d[0].due < cyc) begin
                e = qb_d.pop_front(); chk("b_data missing rvalid", 0, 1);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'h0001_0000 + ($urandom_range(0, 255) << 2);
        return ($urandom_range(0, 127) << 2) | 32'($urandom_range(0, 3));
    endfunction

    logic ig, dg;
    logic pat [4];
    logic [31:0] addr_b;
    logic [31:0] v;

    initial begin
        a_ireq = 0; a_iaddr = 0; a_dreq = 0; a_dwe = 0; a_dbe = 0; a_daddr = 0; a_dwdata = 0;
        b_ireq = 0; b_iaddr = 0; b_dreq = 0; b_dwe = 0; b_dbe = 0; b_daddr = 0; b_dwdata = 0;
        #1;
        // Backdoor load.
        for (int w = 0; w < 128; w++) begin
            v = $urandom;
            if (w == 0) v = 32'h0000_0013;
            if (w == 2 || w == 64) v = 32'h0;
            u_a.mem[w] = v;
            ref_a[w] = v;
        end
        u_a.mem[TOHOST >> 2] = 32'h0;
        ref_a[int'(TOHOST >> 2)] = 32'h0;
        for (int w = 16; w < 24; w++) begin
            v = $urandom;
            u_b.mem[w] = v;
            ref_b[w] = v;
        end

        // Reset values.
        @(negedge clk);
        chk("rst instr_gnt", {31'h0, a_igl}, 0);
        chk("rst instr_rvalid", {31'h0, a_irvalid}, 0);
        chk("rst instr_rdata", a_irdata, 0);
        chk("rst instr_err", {31'h0, a_ierr}, 0);
        chk("rst data_gnt", {31'h0, a_dgnt}, 0);
        chk("rst data_rvalid", {31'h0, a_drvalid}, 0);
        chk("rst data_rdata", a_drdata, 0);
        chk("rst data_err", {31'h0, a_derr}, 0);
        chk("rst halt", {31'h0, a_halt}, 0);
        chk("rst exit_code", {1'b0, a_exit}, 0);
        chk("rst pass", {31'h0, a_pass}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single instruction fetch: grant in the same cycle, rvalid one cycle later.
        a_cycle(1, 32'h0, 0, 0, 4'h0, 0, 0, ig, dg);
        chk("fetch0 gnt", {31'h0, ig}, 1);
        // Partial byte write then read back.
        a_cycle(0, 0, 1, 1, 4'b0101, 32'h100, 32'hAABB_CCDD, ig, dg);
        a_cycle(0, 0, 1, 0, 4'h0, 32'h100, 0, ig, dg);
        // be=0 write is a no-op.
        a_cycle(0, 0, 1, 1, 4'b0000, 32'h8, 32'hFFFF_FFFF, ig, dg);
        a_cycle(0, 0, 1, 0, 4'h0, 32'h8, 0, ig, dg);
        // Out-of-range read and write; word 0 must not alias.
        a_cycle(0, 0, 1, 0, 4'h0, MEM_BASE + MEM_WORDS * 4, 0, ig, dg);
        a_cycle(0, 0, 1, 1, 4'hF, MEM_BASE + MEM_WORDS * 4, 32'h1234_5678, ig, dg);
        a_cycle(1, 32'h0, 1, 0, 4'h0, MEM_BASE + MEM_WORDS * 4, 0, ig, dg);
        // Same-edge collision: instruction read sees the old word.
        a_cycle(1, 32'h14, 1, 1, 4'hF, 32'h14, 32'hDEAD_BEEF, ig, dg);
        a_cycle(1, 32'h14, 0, 0, 4'h0, 0, 0, ig, dg);

        // Randomised traffic on both ports.
        for (int i = 0; i < 300; i++) begin
            a_cycle($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1),
                    $urandom_range(0, 1), 4'($urandom_range(0, 15)), rand_addr(), $urandom,
                    ig, dg);
        end
        idle(3);

        // tohost: first write latches, second is ignored.
        a_cycle(0, 0, 1, 1, 4'hF, TOHOST, 32'h1, ig, dg);
        chk("tohost halt", {31'h0, a_halt}, 1);
        chk("tohost pass", {31'h0, a_pass}, 1);
        chk("tohost exit_code", {1'b0, a_exit}, 0);
        a_cycle(0, 0, 1, 1, 4'hF, TOHOST, 32'h7, ig, dg);
        idle(1);
        chk("tohost2 halt", {31'h0, a_halt}, 1);
        chk("tohost2 pass", {31'h0, a_pass}, 1);
        chk("tohost2 exit_code", {1'b0, a_exit}, 0);
        chk("model halted", {31'h0, ref_halted}, 1);
        // Service continues after halt.
        a_cycle(1, 32'h0, 1, 0, 4'h0, TOHOST, 0, ig, dg);
        idle(3);

        // Outstanding limit on u_b: request held four cycles.
        addr_b = 32'h40;
        for (int k = 0; k < 4; k++) begin
            b_read(addr_b, pat[k]);
            if (pat[k]) addr_b += 4;
        end
        chk("b gnt c0", {31'h0, pat[0]}, 1);
        chk("b gnt c1", {31'h0, pat[1]}, 1);
        chk("b gnt c2", {31'h0, pat[2]}, 0);
        chk("b gnt c3", {31'h0, pat[3]}, 1);
        idle(6);

        // Reset with two reads in flight: they must be dropped.
        b_read(32'h50, ig);
        b_read(32'h54, dg);
        rst_n = 1'b0;
        qb_d.delete();
        b_rv_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        chk("reset drops rvalid", b_rv_cnt, 0);
        b_read(32'h40, ig);
        b_read(32'h44, dg);
        chk("post-reset gnt0", {31'h0, ig}, 1);
        chk("post-reset gnt1", {31'h0, dg}, 1);
        // Memory survives reset.
        a_cycle(0, 0, 1, 0, 4'h0, 32'h100, 0, ig, dg);
        chk("post-reset halt cleared", {31'h0, a_halt}, 0);
        idle(6);

        chk("a_instr queue drained", qa_i.size(), 0);
        chk("a_data queue drained", qa_d.size(), 0);
        chk("b_data queue drained", qb_d.size(), 0);
        chk("b_instr queue drained", qb_i.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
